// File: rtl/frame_pkg.sv
// Shared constants and FSM encoding for frame_sender.
// The SYNC state exists only when FRAME_SYNC_EN is defined.
package frame_pkg;

  localparam int FRAME_WORDS   = 8;
  localparam int SETTLE_CYCLES = 2;
  // Transmitted least-significant byte first: FF FF FF 7F.
  localparam logic [31:0] SYNC_PATTERN = 32'h7FFF_FFFF;

  typedef enum logic [2:0] {
    IDLE,
`ifdef FRAME_SYNC_EN
    SYNC,
`endif
    FETCH,
    SEND_LO,
    SEND_HI
  } stateT;

endpackage

// File: rtl/frame_sender.sv
// Streams 8-word frames from a packet buffer as bytes over a valid/ready link.
// Define FRAME_SYNC_EN to prefix every SYNC_INTERVAL-th frame with FF FF FF 7F.
module frame_sender
  import frame_pkg::*;
#(
  parameter int SYNC_INTERVAL = 16
) (
  input  logic        rdClk,
  input  logic        rst,
  input  logic [15:0] DataVal,
  input  logic        DataReady,
  output logic        DataNext,
  output logic        DataFrameReset,
  output logic [7:0]  TxByte,
  output logic        TxValid,
  input  logic        TxReady,
  input  logic        FrameAbort,
  output logic        Busy,
  output logic [15:0] FrameCount
);

  localparam logic [2:0] LAST_WORD   = 3'(FRAME_WORDS - 1);
  localparam logic [1:0] SETTLE_LOAD = 2'(SETTLE_CYCLES);

  if (SYNC_INTERVAL < 1 || SYNC_INTERVAL > 65535) begin : gBadSyncInterval
    $error("frame_sender: SYNC_INTERVAL must be within 1..65535");
  end

  stateT       stateReg, stateNext;
  logic [2:0]  wordIdxReg, wordIdxNext;
  logic [1:0]  settleCntReg, settleCntNext;
  logic [15:0] wordReg, wordNext;
  logic [15:0] frameCountReg, frameCountNext;
  logic        frameResetReg, frameResetNext;
  logic        abortable;
`ifdef FRAME_SYNC_EN
  logic [15:0] syncCntReg, syncCntNext;
  logic [1:0]  syncIdxReg, syncIdxNext;
  // Set when the current frame was preceded by a sync, so it does not also count down.
  logic        syncedReg, syncedNext;
`endif

  always_ff @(posedge rdClk or posedge rst) begin
    if (rst) begin
      stateReg      <= IDLE;
      wordIdxReg    <= 3'd0;
      settleCntReg  <= 2'd0;
      wordReg       <= 16'd0;
      frameCountReg <= 16'd0;
      frameResetReg <= 1'b0;
`ifdef FRAME_SYNC_EN
      syncCntReg    <= 16'd0;
      syncIdxReg    <= 2'd0;
      syncedReg     <= 1'b0;
`endif
    end else begin
      stateReg      <= stateNext;
      wordIdxReg    <= wordIdxNext;
      settleCntReg  <= settleCntNext;
      wordReg       <= wordNext;
      frameCountReg <= frameCountNext;
      frameResetReg <= frameResetNext;
`ifdef FRAME_SYNC_EN
      syncCntReg    <= syncCntNext;
      syncIdxReg    <= syncIdxNext;
      syncedReg     <= syncedNext;
`endif
    end
  end

  always_comb begin
    stateNext      = stateReg;
    wordIdxNext    = wordIdxReg;
    settleCntNext  = (settleCntReg != 2'd0) ? settleCntReg - 2'd1 : 2'd0;
    wordNext       = wordReg;
    frameCountNext = frameCountReg;
    frameResetNext = 1'b0;
    abortable      = 1'b0;
    DataNext       = 1'b0;
    TxValid        = 1'b0;
    TxByte         = 8'h00;
`ifdef FRAME_SYNC_EN
    syncCntNext    = syncCntReg;
    syncIdxNext    = syncIdxReg;
    syncedNext     = syncedReg;
`endif

    case (stateReg)
      IDLE: begin
        if (DataReady && settleCntReg == 2'd0) begin
`ifdef FRAME_SYNC_EN
          if (syncCntReg == 16'd0) begin
            stateNext   = SYNC;
            syncIdxNext = 2'd0;
          end else begin
            stateNext = FETCH;
          end
`else
          stateNext = FETCH;
`endif
        end
      end
`ifdef FRAME_SYNC_EN
      SYNC: begin
        abortable = 1'b1;
        TxValid   = 1'b1;
        TxByte    = SYNC_PATTERN[{syncIdxReg, 3'b000} +: 8];
        if (TxReady) begin
          if (syncIdxReg == 2'd3) begin
            stateNext   = FETCH;
            syncCntNext = 16'(SYNC_INTERVAL - 1);
            syncedNext  = 1'b1;
          end else begin
            syncIdxNext = syncIdxReg + 2'd1;
          end
        end
      end
`endif
      FETCH: begin
        abortable = 1'b1;
        // Abort wins over a same-cycle fetch so the buffer pointer is never advanced then rewound.
        if (DataReady && settleCntReg == 2'd0 && !FrameAbort) begin
          DataNext      = 1'b1;
          wordNext      = DataVal;
          settleCntNext = SETTLE_LOAD;
          stateNext     = SEND_LO;
        end
      end
      SEND_LO: begin
        abortable = (wordIdxReg != LAST_WORD);
        TxValid   = 1'b1;
        TxByte    = wordReg[7:0];
        if (TxReady) begin
          stateNext = SEND_HI;
        end
      end
      SEND_HI: begin
        abortable = (wordIdxReg != LAST_WORD);
        TxValid   = 1'b1;
        TxByte    = wordReg[15:8];
        if (TxReady) begin
          if (wordIdxReg == LAST_WORD) begin
            wordIdxNext    = 3'd0;
            frameCountNext = frameCountReg + 16'd1;
            stateNext      = IDLE;
`ifdef FRAME_SYNC_EN
            syncedNext = 1'b0;
            if (!syncedReg && syncCntReg != 16'd0) begin
              syncCntNext = syncCntReg - 16'd1;
            end
`endif
          end else begin
            wordIdxNext = wordIdxReg + 3'd1;
            stateNext   = FETCH;
          end
        end
      end
      default: stateNext = IDLE;
    endcase

    if (abortable && FrameAbort) begin
      stateNext      = IDLE;
      wordIdxNext    = 3'd0;
      settleCntNext  = SETTLE_LOAD;
      frameResetNext = 1'b1;
`ifdef FRAME_SYNC_EN
      syncCntNext    = syncCntReg;
      syncedNext     = syncedReg;
`endif
    end
  end

  assign Busy           = (stateReg != IDLE);
  assign FrameCount     = frameCountReg;
  assign DataFrameReset = frameResetReg;

endmodule

// File: tb/tb_frame_sender.sv
// Directed bench for frame_sender with a packet-buffer model and a byte scoreboard.
// Works with or without FRAME_SYNC_EN defined.
module tb_frame_sender;

  localparam int SYNC_INTERVAL = 2;
`ifdef FRAME_SYNC_EN
  localparam bit SYNC_ON = 1'b1;
`else
  localparam bit SYNC_ON = 1'b0;
`endif

  logic        rdClk;
  logic        rst;
  logic [15:0] DataVal;
  logic        DataReady;
  logic        DataNext;
  logic        DataFrameReset;
  logic [7:0]  TxByte;
  logic        TxValid;
  logic        TxReady;
  logic        FrameAbort;
  logic        Busy;
  logic [15:0] FrameCount;

  frame_sender #(.SYNC_INTERVAL(SYNC_INTERVAL)) dut (
    .rdClk         (rdClk),
    .rst           (rst),
    .DataVal       (DataVal),
    .DataReady     (DataReady),
    .DataNext      (DataNext),
    .DataFrameReset(DataFrameReset),
    .TxByte        (TxByte),
    .TxValid       (TxValid),
    .TxReady       (TxReady),
    .FrameAbort    (FrameAbort),
    .Busy          (Busy),
    .FrameCount    (FrameCount)
  );

  initial rdClk = 1'b0;
  always #5 rdClk = ~rdClk;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] wordOf(input int i);
    return {8'(8'h11 + i / 8), 8'(i % 8)};
  endfunction

  // Packet buffer: DataVal follows the read pointer two clocks late.
  logic [15:0] mem [0:63];
  int          wrCount = 0;
  int          rdPtr = 0;
  int          frameStart = 0;
  logic [15:0] valD1;

  assign DataReady = (rdPtr < wrCount);

  always @(posedge rdClk) begin
    valD1   <= mem[rdPtr];
    DataVal <= valD1;
    if (rst || DataFrameReset) begin
      rdPtr <= frameStart;
    end else if (DataNext) begin
      rdPtr <= rdPtr + 1;
      if (rdPtr + 1 - frameStart == 8) frameStart <= rdPtr + 1;
    end
  end

  // Scoreboard and protocol monitor, sampled late in the low clock phase.
  logic [7:0] sbQ[$];
  logic [7:0] expByte;
  int   acceptedBytes = 0;
  int   dnCount = 0;
  int   dfrCount = 0;
  logic prevValid = 1'b0;
  logic prevReady = 1'b0;
  logic prevDataNext = 1'b0;
  logic [7:0] prevByte = 8'h00;

  always @(negedge rdClk) begin
    #3;
    if (rst) begin
      prevValid    = 1'b0;
      prevDataNext = 1'b0;
    end else begin
      if (prevValid && !prevReady) begin
        check("holdValid", 32'(TxValid), 32'd1);
        check("holdByte", 32'(TxByte), 32'(prevByte));
      end
      if (TxValid && TxReady) begin
        if (sbQ.size() == 0) begin
          check("extraByte", 32'(TxByte), 32'hFFFF_FFFF);
        end else begin
          expByte = sbQ.pop_front();
          check("txByte", 32'(TxByte), 32'(expByte));
        end
        acceptedBytes++;
        $display("tx byte %02h (byte #%0d, frameCount %0d)", TxByte, acceptedBytes, FrameCount);
      end
      if (DataNext) begin
        check("dataNextReady", 32'(DataReady), 32'd1);
        check("dataNextGap", 32'(prevDataNext), 32'd0);
        dnCount++;
      end
      if (DataFrameReset) dfrCount++;
      prevValid    = TxValid;
      prevReady    = TxReady;
      prevByte     = TxByte;
      prevDataNext = DataNext;
    end
  end

  task automatic pushSync();
    if (SYNC_ON) begin
      sbQ.push_back(8'hFF);
      sbQ.push_back(8'hFF);
      sbQ.push_back(8'hFF);
      sbQ.push_back(8'h7F);
    end
  endtask

  task automatic pushFrame(input int f, input int nBytes);
    logic [15:0] w;
    for (int k = 0; k < nBytes; k++) begin
      w = wordOf(f * 8 + k / 2);
      sbQ.push_back((k % 2 == 0) ? w[7:0] : w[15:8]);
    end
  endtask

  task automatic waitFrames(input string tag, input int target);
    int n = 0;
    while (FrameCount != 16'(target) && n < 2000) begin
      @(negedge rdClk); #1;
      n++;
    end
    check(tag, 32'(FrameCount), 32'(target));
  endtask

  task automatic waitAccepted(input string tag, input int target, input bit needValid);
    int n = 0;
    while (!(acceptedBytes == target && (TxValid || !needValid)) && n < 2000) begin
      @(negedge rdClk); #1;
      n++;
    end
    check(tag, 32'(acceptedBytes == target && (TxValid || !needValid)), 32'd1);
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, ".DataNext"}, 32'(DataNext), 32'd0);
    check({tag, ".DataFrameReset"}, 32'(DataFrameReset), 32'd0);
    check({tag, ".TxValid"}, 32'(TxValid), 32'd0);
    check({tag, ".TxByte"}, 32'(TxByte), 32'd0);
    check({tag, ".Busy"}, 32'(Busy), 32'd0);
    check({tag, ".FrameCount"}, 32'(FrameCount), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b;
    int dn0;
    int dfr0;
    int syncLen;
    syncLen    = SYNC_ON ? 4 : 0;
    rst        = 1'b1;
    TxReady    = 1'b0;
    FrameAbort = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = wordOf(i);
    repeat (3) @(negedge rdClk);
    #1;
    checkAllZero("reset");

    // Frame 0: one full frame buffered, sink always ready.
    rst     = 1'b0;
    TxReady = 1'b1;
    pushSync();
    pushFrame(0, 16);
    wrCount = 8;
    waitFrames("f0Count", 1);
    check("f0DataNext", 32'(dnCount), 32'd8);
    check("f0Drained", 32'(sbQ.size()), 32'd0);

    // Frame 1: sink stalls for five cycles while byte 3 is offered.
    b = acceptedBytes;
    pushFrame(1, 16);
    wrCount = 16;
    waitAccepted("stallPoint", b + 3, 1'b1);
    TxReady = 1'b0;
    dn0 = dnCount;
    check("stallByte", 32'(TxByte), 32'h12);
    repeat (5) begin
      @(negedge rdClk); #1;
    end
    check("stallDataNext", 32'(dnCount), 32'(dn0));
    check("stallValid", 32'(TxValid), 32'd1);
    TxReady = 1'b1;
    waitFrames("f1Count", 2);
    check("f1Drained", 32'(sbQ.size()), 32'd0);

    // Frame 2: only seven words available until later.
    b = acceptedBytes;
    dn0 = dnCount;
    pushSync();
    pushFrame(2, 16);
    wrCount = 23;
    waitAccepted("holdPoint", b + syncLen + 14, 1'b0);
    repeat (6) begin
      @(negedge rdClk); #1;
    end
    check("holdBusy", 32'(Busy), 32'd1);
    check("holdDataNext", 32'(dnCount - dn0), 32'd7);
    check("holdNoTx", 32'(TxValid), 32'd0);
    check("holdFrameCount", 32'(FrameCount), 32'd2);
    wrCount = 24;
    waitFrames("f2Count", 3);
    check("f2DataNext", 32'(dnCount - dn0), 32'd8);
    check("f2Drained", 32'(sbQ.size()), 32'd0);

    // Frame 3: abort while byte 9 is accepted, then a full replay.
    b = acceptedBytes;
    dfr0 = dfrCount;
    pushFrame(3, 9);
    pushFrame(3, 16);
    wrCount = 32;
    waitAccepted("abortPoint", b + 8, 1'b1);
    FrameAbort = 1'b1;
    @(negedge rdClk); #1;
    FrameAbort = 1'b0;
    check("abortPulse", 32'(DataFrameReset), 32'd1);
    check("abortTxDrop", 32'(TxValid), 32'd0);
    check("abortIdle", 32'(Busy), 32'd0);
    check("abortCountHeld", 32'(FrameCount), 32'd3);
    waitFrames("f3Count", 4);
    check("abortPulses", 32'(dfrCount - dfr0), 32'd1);
    check("f3Drained", 32'(sbQ.size()), 32'd0);

    // Frame 4: reset while frame byte 6 is offered, then a clean restart.
    b = acceptedBytes;
    dfr0 = dfrCount;
    pushSync();
    pushFrame(4, 6);
    wrCount = 40;
    waitAccepted("resetPoint", b + syncLen + 6, 1'b1);
    rst = 1'b1;
    #1;
    checkAllZero("midReset");
    check("midResetDrained", 32'(sbQ.size()), 32'd0);
    repeat (3) @(negedge rdClk);
    #1;
    pushSync();
    pushFrame(4, 16);
    rst = 1'b0;
    waitFrames("restartCount", 1);
    check("restartNoFrameReset", 32'(dfrCount - dfr0), 32'd0);
    check("restartDrained", 32'(sbQ.size()), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/frame_sender.md
FRAME_SENDER -- requirements
Module: frame_sender

Interface
REQ-001 Parameter SYNC_INTERVAL, default 16: number of frames between sync sequences; legal range 1..65535.
REQ-002 rdClk  input  1  system clock; all logic on posedge rdClk.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 DataVal  input  16  word at the packet buffer read pointer; valid 2 cycles after a pointer change.
REQ-005 DataReady  input  1  packet buffer has a readable word.
REQ-006 DataNext  output  1  one-cycle pulse; rising edge advances the buffer read pointer.
REQ-007 DataFrameReset  output  1  one-cycle pulse; rolls the buffer read pointer back to frame start.
REQ-008 TxByte  output  8  outgoing byte.
REQ-009 TxValid  output  1  TxByte valid.
REQ-010 TxReady  input  1  sink accepts TxByte when TxValid&TxReady.
REQ-011 FrameAbort  input  1  sink lost link; restart current frame.
REQ-012 Busy  output  1  frame or sync transfer in progress.
REQ-013 FrameCount  output  16  frames completed, wraps at 16'hFFFF->0.

Function
REQ-014 A frame SHALL be 8 words (16 bytes); a word SHALL be sent low byte first, then high byte.
REQ-015 The FSM SHALL have states IDLE, SYNC, FETCH, SEND_LO, SEND_HI.
REQ-016 IDLE: when DataReady=1 and settle counter=0, go to SYNC if sync is due, else to FETCH; Busy=1 in every state except IDLE.
REQ-017 FETCH: when DataReady=1 and settle counter=0, capture DataVal, drive DataNext=1 for that cycle only, load settle counter with 2, go to SEND_LO.
REQ-018 DataNext SHALL never be high in a cycle where DataReady=0, and SHALL never be high in two consecutive cycles.
REQ-019 SEND_LO and SEND_HI: hold TxValid=1 with a stable TxByte until TxReady=1; TxValid SHALL drop only after acceptance.
REQ-020 After SEND_HI is accepted: if word index <7, increment the index and go to FETCH; if index=7, increment FrameCount, clear the index, and go to IDLE.
REQ-021 The settle counter SHALL decrement each cycle to 0; FETCH and IDLE SHALL not capture while it is nonzero.
REQ-022 Word 7 of a frame SHALL wait in FETCH until DataReady=1, even when the buffer holds exactly one frame.
REQ-023 On FrameAbort=1 in SYNC, or in FETCH/SEND_LO/SEND_HI before DataNext of word 7:
  - pulse DataFrameReset for 1 cycle;
  - drop TxValid the next cycle;
  - clear the word index;
  - load the settle counter with 2;
  - go to IDLE.
  FrameCount SHALL be unchanged.
REQ-024 FrameAbort after DataNext of word 7 SHALL be ignored; the frame completes.
REQ-025 FrameAbort SHALL take priority over a same-cycle TxValid&TxReady; the byte counts as transferred, but the frame still aborts.
REQ-026 FrameAbort in IDLE SHALL be ignored.

Reset
REQ-027 While rst=1, all outputs SHALL be 0: DataNext, DataFrameReset, TxValid, TxByte, Busy, FrameCount.
REQ-028 While rst=1, the FSM SHALL be in IDLE, with word index=0, settle counter=0, and sync counter=0.
REQ-029 The first frame after reset SHALL be preceded by a sync sequence when FRAME_SYNC_EN is defined.
REQ-030 Reset asserted mid-frame SHALL abandon the frame without a DataFrameReset pulse.

Configuration
REQ-031 Macro FRAME_SYNC_EN defined: before a frame, when the sync counter=0, SYNC SHALL emit bytes FF FF FF 7F using the REQ-019 handshake, then go to FETCH.
REQ-032 With FRAME_SYNC_EN defined, the sync counter SHALL reload with SYNC_INTERVAL-1 after a sync and decrement per completed frame.
REQ-033 Macro FRAME_SYNC_EN undefined: the SYNC state, sync counter, and SYNC_INTERVAL logic SHALL be absent; IDLE SHALL go directly to FETCH.

Structure
REQ-034 Shared package frame_pkg SHALL hold FRAME_WORDS=8, the sync pattern constant, SETTLE_CYCLES=2, and the FSM state enum.
REQ-035 The block SHALL be a single module with no sub-module.

Verification
REQ-036 Words 16'h1100..16'h1107 ready, TxReady=1 -> bytes FF FF FF 7F, then 00 11 01 11 .. 07 11; FrameCount=1.
REQ-037 TxReady low for 5 cycles at byte 3 -> TxValid and TxByte stay stable; no extra DataNext; all 16 bytes delivered in order.
REQ-038 FrameAbort at byte 9 -> one DataFrameReset pulse; buffer replays from word 0; retransmitted frame is byte-identical; FrameCount increments once.
REQ-039 DataReady dropped before word 7 -> FSM holds in FETCH with DataNext=0; on DataReady=1, word 7 is sent after one DataNext pulse.
REQ-040 SYNC_INTERVAL=2, 5 frames -> sync precedes frames 1, 3, 5 only; without FRAME_SYNC_EN, no FF FF FF 7F appears.
REQ-041 rst asserted at byte 6 -> all outputs 0 immediately; after release, sync and frame restart cleanly.
